// File: rtl/coll_pkg.sv
// Shared collision-map types and constants for the tile-probe path.
package coll_pkg;

  localparam int TILES_X    = 64;
  localparam int TILES_Y    = 48;
  localparam int TILE_SHIFT = 4;

  typedef logic [1:0] tile_code_t;

  localparam tile_code_t TILE_EMPTY = 2'b00;
  localparam tile_code_t TILE_SOLID = 2'b01;

  typedef enum logic [1:0] {
    PROBE_BELOW,
    PROBE_ABOVE,
    PROBE_LEFT,
    PROBE_RIGHT
  } probe_id_t;

endpackage

// File: rtl/collision_tile_arbiter_rr_arbiter.sv
// Combinational winner picker for the tile-probe arbiter.
// COLL_ARB_FIXED_PRIO_EN: lowest eligible index always wins and ptr is ignored.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);
  import coll_pkg::*;

  assign found = |eligible;

`ifdef COLL_ARB_FIXED_PRIO_EN
  logic [PW-1:0] unused_ptr;
  assign unused_ptr = ptr;

  assign winner = eligible & (~eligible + 1'b1);
`else
  logic [N-1:0] upper;

  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = eligible[i] && (i >= int'(ptr));
    end
  end

  // Lowest set bit at or above ptr, else wrap to the lowest set bit overall.
  assign winner = (|upper) ? (upper & (~upper + 1'b1))
                           : (eligible & (~eligible + 1'b1));
`endif

endmodule

// File: rtl/collision_tile_arbiter.sv
// Shares the collision map ROM between tile probes with a 3-cycle fixed latency.
// COLL_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest) instead of round-robin.
module collision_tile_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         TILES_X  = coll_pkg::TILES_X,
  parameter int         TILES_Y  = coll_pkg::TILES_Y,
  parameter int         ROM_AW   = 12,
  parameter logic [1:0] OOB_CODE = coll_pkg::TILE_SOLID
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*7-1:0] req_tile_x,
  input  logic [N_REQ*6-1:0] req_tile_y,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [N_REQ*2-1:0] rsp_tile,
  output logic               rom_en,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [1:0]         rom_data,
  output logic               busy
);
  import coll_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int XB = $clog2(TILES_X);
  localparam int XW = 7;
  localparam int YW = 6;

  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] in_flight;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] win_oh;
  logic             found;
  logic [PW-1:0]    win_idx;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic             in_map;

  logic             s1_vld, s1_oob, s2_vld, s2_oob;
  logic [N_REQ-1:0] s1_tag, s2_tag;
  tile_code_t       rsp_code;

  assign eligible = req & ~in_flight;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (win_oh),
    .found    (found)
  );

  always_comb begin
    win_idx = '0;
    sel_x   = '0;
    sel_y   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx = PW'(i);
        sel_x   = req_tile_x[XW*i +: XW];
        sel_y   = req_tile_y[YW*i +: YW];
      end
    end
  end

  assign in_map   = (32'(sel_x) < TILES_X) && (32'(sel_y) < TILES_Y);
  assign rsp_code = s2_oob ? OOB_CODE : rom_data;
  assign busy     = |in_flight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_tile  <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      ptr       <= '0;
      in_flight <= '0;
      s1_vld    <= 1'b0;
      s1_oob    <= 1'b0;
      s1_tag    <= '0;
      s2_vld    <= 1'b0;
      s2_oob    <= 1'b0;
      s2_tag    <= '0;
    end else begin
      gnt    <= win_oh;
      rom_en <= found && in_map;
      if (found && in_map) begin
        rom_addr <= ROM_AW'({sel_y, sel_x[XB-1:0]});
      end
      if (found) begin
        ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end

      s1_vld <= found;
      s1_tag <= win_oh;
      s1_oob <= !in_map;
      s2_vld <= s1_vld;
      s2_tag <= s1_tag;
      s2_oob <= s1_oob;

      rsp_valid <= s2_vld ? s2_tag : '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (s2_vld && s2_tag[i]) begin
          rsp_tile[2*i +: 2] <= rsp_code;
        end
      end

      // A set needs in_flight=0 and a clear needs in_flight=1, so they never collide.
      in_flight <= (in_flight | win_oh) & ~(s2_vld ? s2_tag : '0);
    end
  end

endmodule

// File: tb/tb_collision_tile_arbiter.sv
// Scoreboard bench for collision_tile_arbiter with a behavioural collision ROM.
module tb_collision_tile_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [N*7-1:0] req_tile_x;
  logic [N*6-1:0] req_tile_y;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [N*2-1:0] rsp_tile;
  logic           rom_en;
  logic [11:0]    rom_addr;
  logic [1:0]     rom_data = 2'b00;
  logic           busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int val;
    int cyc;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rom_q[$];
  exp_t rsp_q[$];
  exp_t me;
  int   last_code [N];

  collision_tile_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_tile_x (req_tile_x),
    .req_tile_y (req_tile_y),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_tile   (rsp_tile),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] rom_fn(input int a);
    int s;
    s = a + (a >> 5);
    return s[1:0];
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_fn(int'(rom_addr));

  function automatic exp_t mk(input int a, input int b, input int c);
    exp_t e;
    e.idx = a;
    e.val = b;
    e.cyc = c;
    return e;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (gnt != '0) begin
      check("gnt_onehot", $countones(gnt), 1);
      if (gnt_q.size() == 0) check("gnt_unexpected", int'(gnt), 0);
      else begin
        me = gnt_q.pop_front();
        check("gnt_idx", oh_idx(gnt), me.idx);
        check("gnt_cyc", cyc, me.cyc);
      end
    end
    if (rom_en) begin
      if (rom_q.size() == 0) check("rom_en_unexpected", int'(rom_addr), -1);
      else begin
        me = rom_q.pop_front();
        check("rom_addr", int'(rom_addr), me.idx);
        check("rom_cyc", cyc, me.cyc);
      end
    end
    if (rsp_valid != '0) begin
      check("rsp_onehot", $countones(rsp_valid), 1);
      if (rsp_q.size() == 0) check("rsp_unexpected", int'(rsp_valid), 0);
      else begin
        me = rsp_q.pop_front();
        check("rsp_idx", oh_idx(rsp_valid), me.idx);
        check("rsp_tile", int'(rsp_tile[2*oh_idx(rsp_valid) +: 2]), me.val);
        check("rsp_cyc", cyc, me.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input int x, input int y);
    req_tile_x[7*i +: 7] = 7'(x);
    req_tile_y[6*i +: 6] = 6'(y);
    req[i] = 1'b1;
  endtask

  // Arbitrated in cycle arb: grant and ROM read in arb+1, response in arb+3.
  task automatic expect_read(input int i, input int x, input int y, input int arb, input bit with_rsp);
    int code;
    gnt_q.push_back(mk(i, 0, arb + 1));
    if (x < 64 && y < 48) begin
      rom_q.push_back(mk(y * 64 + x, 0, arb + 1));
      code = int'(rom_fn(y * 64 + x));
    end else begin
      code = 1;
    end
    if (with_rsp) begin
      rsp_q.push_back(mk(i, code, arb + 3));
      last_code[i] = code;
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    req = '0;
    req_tile_x = '0;
    req_tile_y = '0;
    tick(2);
    check("rst_ctrl", int'({gnt, rsp_valid, rom_en, busy}), 0);
    check("rst_rsp_tile", int'(rsp_tile), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    rst_n = 1'b1;
    tick(1);

    // Single request, address 0x143.
    c = cyc;
    set_req(0, 3, 5);
    expect_read(0, 3, 5, c, 1'b1);
    check("t1_addr_model", 5 * 64 + 3, 'h143);
    tick(1);
    req[0] = 1'b0;
    check("t1_busy_inflight", int'(busy), 1);
    tick(2);
    check("t1_busy_done", int'(busy), 0);
    tick(3);

    // All four together, held until each sees its grant.
    do_reset();
    c = cyc;
    set_req(0, 1, 0);
    set_req(1, 10, 2);
    set_req(2, 63, 47);
    set_req(3, 0, 47);
    expect_read(0, 1, 0, c, 1'b1);
    expect_read(1, 10, 2, c + 1, 1'b1);
    expect_read(2, 63, 47, c + 2, 1'b1);
    expect_read(3, 0, 47, c + 3, 1'b1);
    for (int i = 0; i < N; i++) begin
      tick(1);
      req[i] = 1'b0;
      req_tile_x[7*i +: 7] = 7'h7f;
    end
    tick(6);

    // Fairness: 0 and 2 held continuously.
    do_reset();
    c = cyc;
    set_req(0, 5, 5);
    set_req(2, 20, 30);
    for (int k = 0; k < 3; k++) begin
      expect_read(0, 5, 5, c + 3 * k, 1'b1);
      expect_read(2, 20, 30, c + 3 * k + 1, 1'b1);
    end
    tick(8);
    req = '0;
    tick(4);

    // Out-of-range column, then out-of-range row.
    c = cyc;
    set_req(3, 64, 10);
    expect_read(3, 64, 10, c, 1'b1);
    tick(1);
    req[3] = 1'b0;
    tick(4);
    c = cyc;
    set_req(3, 5, 48);
    expect_read(3, 5, 48, c, 1'b1);
    tick(1);
    req[3] = 1'b0;
    tick(4);
    check("hold_tile0", int'(rsp_tile[1:0]), last_code[0]);
    check("hold_tile2", int'(rsp_tile[5:4]), last_code[2]);

    // Reset with two reads in flight.
    c = cyc;
    set_req(0, 7, 7);
    set_req(1, 8, 8);
    expect_read(0, 7, 7, c, 1'b0);
    expect_read(1, 8, 8, c + 1, 1'b0);
    tick(1);
    req[0] = 1'b0;
    tick(1);
    req[1] = 1'b0;
    check("t5_busy", int'(busy), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", int'({gnt, rsp_valid, rom_en, busy}), 0);
    check("t5_rst_tile", int'(rsp_tile), 0);
    check("t5_rst_addr", int'(rom_addr), 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    c = cyc;
    set_req(0, 2, 3);
    set_req(3, 9, 9);
    expect_read(0, 2, 3, c, 1'b1);
    expect_read(3, 9, 9, c + 1, 1'b1);
    tick(1);
    req[0] = 1'b0;
    tick(1);
    req[3] = 1'b0;
    tick(6);

`ifdef COLL_ARB_FIXED_PRIO_EN
    c = cyc;
    set_req(1, 4, 4);
    set_req(3, 6, 6);
    expect_read(1, 4, 4, c, 1'b1);
    expect_read(3, 6, 6, c + 1, 1'b1);
    expect_read(1, 4, 4, c + 3, 1'b1);
    expect_read(3, 6, 6, c + 4, 1'b1);
    tick(5);
    req = '0;
    tick(6);
`endif

    tick(3);
    check("gnt_q_empty", gnt_q.size(), 0);
    check("rom_q_empty", rom_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
